// File: rtl/arp_pkg.sv
// ============================================================================
// Module : arp_pkg
// Brief  : Shared ARP protocol constants and FSM state type for the ARP
//          request decoder and reply encoder.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package arp_pkg;

  localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
  localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
  localparam logic [7:0]  ARP_HLEN       = 8'd6;
  localparam logic [7:0]  ARP_PLEN       = 8'd4;
  localparam logic [15:0] ARP_OPER_REQ   = 16'h0001;
  localparam logic [15:0] ARP_OPER_REP   = 16'h0002;
  localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;
  localparam int          ARP_BODY_LEN   = 28;
  localparam int          ETH_HDR_LEN    = 14;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HDR  = 2'd1,
    S_ARP  = 2'd2
  } arp_state_e;

endpackage

`default_nettype wire

// File: rtl/arp_reply_encode_if.sv
// ============================================================================
// Module : arp_reply_encode_if
// Brief  : Decoded-request inputs and reply byte stream of arp_reply_encode.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface arp_reply_encode_if;

  logic        req_valid;
  logic        req_err;
  logic [47:0] sha;
  logic [31:0] spa;
  logic [31:0] tpa;
  logic [7:0]  dout;
  logic        dout_valid;
  logic        dout_ready;
  logic        dout_last;
  logic        busy;
  logic        req_drop;

  // master: upstream decoder plus downstream sink; slave: the encoder
  modport master (
    output req_valid, req_err, sha, spa, tpa, dout_ready,
    input  dout, dout_valid, dout_last, busy, req_drop
  );

  modport slave (
    input  req_valid, req_err, sha, spa, tpa, dout_ready,
    output dout, dout_valid, dout_last, busy, req_drop
  );

endinterface

`default_nettype wire

// File: rtl/arp_reply_encode_byte_sel.sv
// ============================================================================
// Module : arp_byte_sel
// Brief  : Combinational mapping of (state, index, latched addresses) to the
//          outgoing reply byte. Header mux present only with ARP_ETH_HDR_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module arp_byte_sel
  import arp_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01,
  parameter logic [31:0] LOCAL_IP  = 32'hC0_A8_01_64
) (
  input  logic [1:0]  state,
  input  logic [4:0]  idx,
  input  logic [47:0] sha,
  input  logic [31:0] spa,
  output logic [7:0]  dbyte
);

  localparam logic [1:0] c_ST_ARP = S_ARP;

  logic [223:0] w_body;
  logic [223:0] w_body_sh;

  // Fields packed in wire order so byte n is the top byte after shifting by n
  assign w_body    = {ARP_HTYPE_ETH, ARP_PTYPE_IPV4, ARP_HLEN, ARP_PLEN,
                      ARP_OPER_REP, LOCAL_MAC, LOCAL_IP, sha, spa};
  assign w_body_sh = w_body << {idx, 3'b000};

`ifdef ARP_ETH_HDR_EN
  localparam logic [1:0] c_ST_HDR = S_HDR;

  logic [111:0] w_hdr;
  logic [111:0] w_hdr_sh;

  assign w_hdr    = {sha, LOCAL_MAC, ETHERTYPE_ARP};
  assign w_hdr_sh = w_hdr << {idx, 3'b000};
`endif

  always_comb begin
    dbyte = 8'h00;
    if (state == c_ST_ARP) begin
      dbyte = w_body_sh[223:216];
    end
`ifdef ARP_ETH_HDR_EN
    else if (state == c_ST_HDR) begin
      dbyte = w_hdr_sh[111:104];
    end
`endif
  end

endmodule

`default_nettype wire

// File: rtl/arp_reply_encode.sv
// ============================================================================
// Module : arp_reply_encode
// Brief  : Builds and streams an ARP reply (optionally with Ethernet header,
//          enabled by macro ARP_ETH_HDR_EN) for requests targeting LOCAL_IP.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module arp_reply_encode
  import arp_pkg::*;
#(
  parameter logic [47:0] LOCAL_MAC = 48'h02_00_00_00_00_01,
  parameter logic [31:0] LOCAL_IP  = 32'hC0_A8_01_64
) (
  input  logic              clk,
  input  logic              rst,
  arp_reply_encode_if.slave bus
);

  localparam logic [1:0] c_ST_IDLE  = S_IDLE;
  localparam logic [1:0] c_ST_ARP   = S_ARP;
  localparam logic [4:0] c_ARP_LAST = 5'(ARP_BODY_LEN - 1);
`ifdef ARP_ETH_HDR_EN
  localparam logic [1:0] c_ST_HDR   = S_HDR;
  localparam logic [4:0] c_HDR_LAST = 5'(ETH_HDR_LEN - 1);
`endif

  logic [1:0]  r_state, w_state_nxt;
  logic [4:0]  r_idx,   w_idx_nxt;
  logic [47:0] r_sha,   w_sha_nxt;
  logic [31:0] r_spa,   w_spa_nxt;
  logic [7:0]  r_dout;
  logic        r_valid;
  logic        r_last;
  logic        r_drop;
  logic [7:0]  w_byte;
  logic        w_qual;
  logic        w_hs;

  assign w_qual = bus.req_valid && !bus.req_err && (bus.tpa == LOCAL_IP);
  assign w_hs   = r_valid && bus.dout_ready;

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    w_sha_nxt   = r_sha;
    w_spa_nxt   = r_spa;
    case (r_state)
      c_ST_IDLE: begin
        if (w_qual) begin
          w_sha_nxt = bus.sha;
          w_spa_nxt = bus.spa;
          w_idx_nxt = 5'd0;
`ifdef ARP_ETH_HDR_EN
          w_state_nxt = c_ST_HDR;
`else
          w_state_nxt = c_ST_ARP;
`endif
        end
      end
`ifdef ARP_ETH_HDR_EN
      c_ST_HDR: begin
        if (w_hs) begin
          if (r_idx == c_HDR_LAST) begin
            w_state_nxt = c_ST_ARP;
            w_idx_nxt   = 5'd0;
          end else begin
            w_idx_nxt = r_idx + 5'd1;
          end
        end
      end
`endif
      c_ST_ARP: begin
        if (w_hs) begin
          if (r_idx == c_ARP_LAST) begin
            w_state_nxt = c_ST_IDLE;
            w_idx_nxt   = 5'd0;
          end else begin
            w_idx_nxt = r_idx + 5'd1;
          end
        end
      end
      default: begin
        w_state_nxt = c_ST_IDLE;
        w_idx_nxt   = 5'd0;
      end
    endcase
  end

  // Selector looks at next-cycle state so the output byte can be registered
  arp_byte_sel #(
    .LOCAL_MAC (LOCAL_MAC),
    .LOCAL_IP  (LOCAL_IP)
  ) u_byte_sel (
    .state (w_state_nxt),
    .idx   (w_idx_nxt),
    .sha   (w_sha_nxt),
    .spa   (w_spa_nxt),
    .dbyte (w_byte)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_ST_IDLE;
      r_idx   <= 5'd0;
      r_sha   <= 48'd0;
      r_spa   <= 32'd0;
      r_dout  <= 8'h00;
      r_valid <= 1'b0;
      r_last  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      r_sha   <= w_sha_nxt;
      r_spa   <= w_spa_nxt;
      r_dout  <= w_byte;
      r_valid <= (w_state_nxt != c_ST_IDLE);
      r_last  <= (w_state_nxt == c_ST_ARP) && (w_idx_nxt == c_ARP_LAST);
      r_drop  <= w_qual && (r_state != c_ST_IDLE);
    end
  end

  assign bus.dout       = r_dout;
  assign bus.dout_valid = r_valid;
  assign bus.dout_last  = r_last;
  assign bus.busy       = (r_state != c_ST_IDLE);
  assign bus.req_drop   = r_drop;

endmodule

`default_nettype wire

// File: tb/tb_arp_reply_encode.sv
// ============================================================================
// Module : tb_arp_reply_encode
// Brief  : Scoreboard bench for arp_reply_encode; frame length follows
//          ARP_ETH_HDR_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_arp_reply_encode;

  localparam logic [47:0] LMAC = 48'h02_00_00_00_00_01;
  localparam logic [31:0] LIP  = 32'hC0_A8_01_64;
`ifdef ARP_ETH_HDR_EN
  localparam int HL = 14;
`else
  localparam int HL = 0;
`endif
  localparam int FL = HL + 28;

  typedef struct packed {
    logic [7:0] b;
    logic       last;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;
  int   hs_count = 0;
  logic [7:0] held = 8'h00;
  logic       held_v = 1'b0;

  always #5 clk = ~clk;

  arp_reply_encode_if bus_if ();

  arp_reply_encode #(
    .LOCAL_MAC (LMAC),
    .LOCAL_IP  (LIP)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference frame written out field by field in wire order
  task automatic push_frame(input logic [47:0] s, input logic [31:0] p);
    logic [335:0] f;
    f = {s, LMAC, 16'h0806,
         16'h0001, 16'h0800, 8'h06, 8'h04, 16'h0002, LMAC, LIP, s, p};
    for (int i = 42 - FL; i < 42; i++) begin
      sb.push_back({f[335 - 8*i -: 8], (i == 41)});
    end
  endtask

  task automatic send_req(input logic err, input logic [47:0] s, input logic [31:0] p,
                          input logic [31:0] t, input bit expect_accept);
    @(posedge clk); #1;
    bus_if.req_valid = 1'b1;
    bus_if.req_err   = err;
    bus_if.sha       = s;
    bus_if.spa       = p;
    bus_if.tpa       = t;
    if (expect_accept) push_frame(s, p);
    @(posedge clk); #1;
    bus_if.req_valid = 1'b0;
    bus_if.req_err   = 1'b0;
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check(tag, 64'(sb.size()), 64'd0);
    sb.delete();
  endtask

  task automatic wait_hs(input int target, input int budget);
    int n = 0;
    while (hs_count < target && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
    check("wait_hs_reached", 64'(hs_count >= target), 64'd1);
  endtask

  // Monitor: pops the scoreboard on each handshake, checks hold on stalls
  always @(negedge clk) begin
    if (rst) begin
      held_v <= 1'b0;
    end else begin
      if (held_v && bus_if.dout_valid) check("hold_dout", 64'(bus_if.dout), 64'(held));
      if (bus_if.dout_valid && !bus_if.dout_ready) begin
        held   <= bus_if.dout;
        held_v <= 1'b1;
      end else begin
        held_v <= 1'b0;
      end
      if (bus_if.dout_valid && bus_if.dout_ready) begin
        check("byte_expected", 64'(sb.size() != 0), 64'd1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          check("dout", 64'(bus_if.dout), 64'(e.b));
          check("dout_last", 64'(bus_if.dout_last), 64'(e.last));
        end
        hs_count <= hs_count + 1;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int c;
    rst               = 1'b1;
    bus_if.req_valid  = 1'b0;
    bus_if.req_err    = 1'b0;
    bus_if.sha        = 48'd0;
    bus_if.spa        = 32'd0;
    bus_if.tpa        = 32'd0;
    bus_if.dout_ready = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_dout", 64'(bus_if.dout), 64'd0);
    check("rst_valid", 64'(bus_if.dout_valid), 64'd0);
    check("rst_last", 64'(bus_if.dout_last), 64'd0);
    check("rst_busy", 64'(bus_if.busy), 64'd0);
    check("rst_drop", 64'(bus_if.req_drop), 64'd0);
    rst = 1'b0;

    // Basic frame, continuous ready: no bubbles, exact length
    send_req(1'b0, 48'hAA_BB_CC_DD_EE_FF, 32'h0A_00_00_05, LIP, 1'b1);
    for (int k = 0; k < FL; k++) begin
      @(negedge clk);
      check("frame_valid", 64'(bus_if.dout_valid), 64'd1);
    end
    @(negedge clk);
    check("frame_end_valid", 64'(bus_if.dout_valid), 64'd0);
    check("frame_end_busy", 64'(bus_if.busy), 64'd0);
    wait_drain("frame1_drain", 10);

    // Ignored requests: TPA mismatch, then decoder error
    send_req(1'b0, 48'h11_22_33_44_55_66, 32'h0A_00_00_07, 32'hC0_A8_01_65, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("ign_tpa_valid", 64'(bus_if.dout_valid), 64'd0);
      check("ign_tpa_busy", 64'(bus_if.busy), 64'd0);
      check("ign_tpa_drop", 64'(bus_if.req_drop), 64'd0);
    end
    send_req(1'b1, 48'h11_22_33_44_55_66, 32'h0A_00_00_07, LIP, 1'b0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("ign_err_valid", 64'(bus_if.dout_valid), 64'd0);
      check("ign_err_busy", 64'(bus_if.busy), 64'd0);
      check("ign_err_drop", 64'(bus_if.req_drop), 64'd0);
    end

    // Back-pressure: ready pattern 1,0,0,1
    send_req(1'b0, 48'h12_34_56_78_9A_BC, 32'h0A_01_02_03, LIP, 1'b1);
    c = 0;
    while (sb.size() != 0 && c < 400) begin
      @(posedge clk); #1;
      bus_if.dout_ready = ((c % 4) == 0) || ((c % 4) == 3);
      c++;
    end
    bus_if.dout_ready = 1'b1;
    wait_drain("bp_drain", 4);
    repeat (2) @(negedge clk);
    check("bp_end_valid", 64'(bus_if.dout_valid), 64'd0);

    // Qualifying request mid-frame is dropped
    send_req(1'b0, 48'hDE_AD_BE_EF_00_01, 32'h0A_00_00_09, LIP, 1'b1);
    base = hs_count;
    wait_hs(base + 10, 100);
    send_req(1'b0, 48'h66_55_44_33_22_11, 32'h0A_00_00_0B, LIP, 1'b0);
    check("drop_pulse", 64'(bus_if.req_drop), 64'd1);
    @(posedge clk); #1;
    check("drop_one_cycle", 64'(bus_if.req_drop), 64'd0);
    wait_drain("drop_drain", 100);
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("no_second_frame", 64'(bus_if.dout_valid), 64'd0);
    end

    // Reset at ARP byte 5, then a fresh frame
    send_req(1'b0, 48'hCA_FE_BA_BE_00_02, 32'h0A_00_00_0C, LIP, 1'b1);
    base = hs_count;
    wait_hs(base + HL + 5, 100);
    rst = 1'b1;
    #1;
    check("midrst_dout", 64'(bus_if.dout), 64'd0);
    check("midrst_valid", 64'(bus_if.dout_valid), 64'd0);
    check("midrst_last", 64'(bus_if.dout_last), 64'd0);
    check("midrst_busy", 64'(bus_if.busy), 64'd0);
    sb.delete();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_hold_valid", 64'(bus_if.dout_valid), 64'd0);
    rst = 1'b0;
    send_req(1'b0, 48'h0F_0E_0D_0C_0B_0A, 32'h0A_00_00_0D, LIP, 1'b1);
    wait_drain("post_rst_drain", 100);

    // Back-to-back: second request on the idle cycle after the last byte
    send_req(1'b0, 48'hAA_BB_CC_DD_EE_FF, 32'h0A_00_00_05, LIP, 1'b1);
    wait_drain("b2b_first_drain", 100);
    check("b2b_gap_valid", 64'(bus_if.dout_valid), 64'd0);
    bus_if.req_valid = 1'b1;
    bus_if.sha       = 48'h01_02_03_04_05_06;
    bus_if.spa       = 32'h0A_00_00_0E;
    bus_if.tpa       = LIP;
    push_frame(48'h01_02_03_04_05_06, 32'h0A_00_00_0E);
    @(posedge clk); #1;
    bus_if.req_valid = 1'b0;
    check("b2b_second_valid", 64'(bus_if.dout_valid), 64'd1);
    wait_drain("b2b_second_drain", 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/arp_reply_encode.md
# arp_reply_encode

Builds and serializes an ARP reply frame in response to a decoded ARP request. Sits directly downstream of the ARP request decoder: it takes the decoded sender hardware and protocol addresses plus the target protocol address on the decoder's `done` pulse. If the request targets this node's IP, it streams a 28-byte ARP reply, optionally preceded by a 14-byte Ethernet header, as a byte stream with a valid/ready handshake toward the MAC transmit path.

## Interface
- `LOCAL_MAC`, default 48'h02_00_00_00_00_01: this node's MAC address, used as reply SHA and Ethernet source.
- `LOCAL_IP`, default 32'hC0_A8_01_64 (192.168.1.100): this node's IPv4 address, used for the TPA match and as reply SPA.
- `clk`  in  1  single clock; all logic on posedge.
- `rst`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  one-cycle pulse; the decoded request fields are valid this cycle.
- `req_err`  in  1  decoder error flag, sampled with `req_valid`.
- `sha`  in  48  requester MAC address.
- `spa`  in  32  requester IPv4 address.
- `tpa`  in  32  requested IPv4 address.
- `dout`  out  8  reply byte.
- `dout_valid`  out  1  `dout` holds a valid byte.
- `dout_ready`  in  1  downstream accepts a byte when high together with `dout_valid`.
- `dout_last`  out  1  high with the final byte of the frame.
- `busy`  out  1  high while a reply is latched or being sent.
- `req_drop`  out  1  one-cycle pulse: a request that would have been answered was discarded because `busy` was high.

## Operation
- Reset values: `dout`=0, `dout_valid`=0, `dout_last`=0, `busy`=0, `req_drop`=0. The FSM resets to IDLE, the byte index to 0, and the latched `sha`/`spa` registers to 0.
- **Request acceptance.** A request is accepted when all of the following hold in the same cycle: FSM in IDLE, `req_valid`=1, `req_err`=0, and `tpa`==`LOCAL_IP`.
  - On acceptance, `sha` and `spa` are latched, the byte index is cleared, and the FSM moves to HDR (macro defined) or ARP (macro undefined).
- **Ignored requests.**
  - Requests with `req_err`=1 or a TPA mismatch are silently ignored and never raise `req_drop`.
  - A qualifying request (no error, TPA matches) arriving while not in IDLE is ignored and raises `req_drop` for one cycle.
- **FSM states.**
  - IDLE: waits for an accepted request.
  - HDR: sends 14 bytes, index 0–13, then moves to ARP with the index reset to 0.
  - ARP: sends 28 bytes, index 0–27. The index advances only on a handshake (`dout_valid && dout_ready`).
  - On the handshake of ARP byte 27, the FSM returns to IDLE.
- **Ethernet header** (HDR, in order): destination = latched `sha`, source = `LOCAL_MAC`, EtherType 0x0806.
- **ARP body** (ARP, in order): HTYPE 0x0001, PTYPE 0x0800, HLEN 0x06, PLEN 0x04, OPER 0x0002, SHA = `LOCAL_MAC`, SPA = `LOCAL_IP`, THA = latched `sha`, TPA = latched `spa`.
- Every multi-byte field is sent most-significant byte first (network order).
- `dout_last` is high only while presenting ARP byte 27.
- `busy` is high in every state except IDLE.

## Timing
- Acceptance in cycle N gives `dout_valid`=1 with the first byte at N+1. All outputs are registered.
- `dout`, `dout_valid` and `dout_last` hold stable while `dout_valid && !dout_ready`. There are no bubbles while `dout_ready` stays high.
- Full frame with continuous ready: 42 cycles (macro defined) or 28 cycles (undefined).
- `dout_valid` falls in the cycle after the last handshake.
- A qualifying request in that same cycle, with the FSM back in IDLE, is accepted. This gives back-to-back frames with exactly one idle cycle between them.
- Asserting `rst` mid-frame immediately forces all outputs to their reset values. The partial frame is abandoned and is not resumed.
- `req_valid` and `dout_ready` may toggle in any cycle. Only the sampled values at the clock edge matter.

## Configuration
- `ARP_ETH_HDR_EN` defined:
  - HDR state is present; the frame is 42 bytes.
  - The first byte after acceptance is `sha[47:40]`.
- `ARP_ETH_HDR_EN` undefined:
  - The HDR state and the header mux are removed; the frame is 28 bytes.
  - The first byte is 0x00 (HTYPE high byte).

## Structure
- Shared package `arp_pkg` holds:
  - constants ARP_HTYPE_ETH=16'h0001, ARP_PTYPE_IPV4=16'h0800, ARP_HLEN=8'd6, ARP_PLEN=8'd4, ARP_OPER_REQ=16'h0001, ARP_OPER_REP=16'h0002, ETHERTYPE_ARP=16'h0806, ARP_BODY_LEN=28, ETH_HDR_LEN=14;
  - the FSM state enum type.
- The decoder imports the same package.
- One sub-module, `arp_byte_sel`: combinational byte selector mapping (state, index, latched addresses, parameters) to the outgoing byte. The FSM, index counter and output registers stay in the top module.

## Test plan
- Macro defined, `dout_ready` held 1. Request with sha=48'hAA_BB_CC_DD_EE_FF, spa=32'h0A_00_00_05, tpa=`LOCAL_IP`, err=0.
  - Required: 42 consecutive bytes AA BB CC DD EE FF 02 00 00 00 00 01 08 06 00 01 08 00 06 04 00 02 02 00 00 00 00 01 C0 A8 01 64 AA BB CC DD EE FF 0A 00 00 05.
  - `dout_last` high only on the final 0x05.
- Request with tpa=32'hC0_A8_01_65, or with `req_err`=1 and a matching TPA.
  - Required: `dout_valid` stays 0, `busy` stays 0, `req_drop` stays 0.
- `dout_ready` toggled 1,0,0,1 repeating during a frame.
  - Required: `dout` unchanged during low-ready cycles, no byte skipped or duplicated, all 42 bytes in order.
- Second qualifying request pulsed at frame byte 10.
  - Required: one-cycle `req_drop` pulse, current frame unaffected, no second frame.
- `rst` asserted at ARP byte 5, then released, then a new request issued.
  - Required: outputs 0 during reset; the new frame starts from byte 0 with a correct header.
- Macro undefined, request as in the first test.
  - Required: 28 bytes starting 00 01 08 00, ending 0A 00 00 05; `dout_last` on byte 27.
